// File: rtl/riscv_bpu.sv
// Purpose : direct-mapped BTB with per-entry saturating direction counters, plus mispredict redirect.
// Latency : lookup and redirect are combinational (0 cycles); table writes are visible the cycle after.
// Backpressure: none; one lookup and at most one training update accepted every cycle, no stall path.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   pc_i -> hit_o, taken_o, predicted_pc_o          IF-stage lookup
//   flush_i                       invalidate every entry (wins over a same-cycle update)
//   upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
//   upd_pred_taken_i, upd_pred_pc_i                 EX-stage training / resolution
//   mispredict_o, redirect_pc_o   redirect to the correct next PC
//   No_branch_o, No_mispredict_o  performance counters
//
// Optional feature macro: RISCV_BPU_PERF_CNT_EN
//   defined   -> saturating 32-bit resolved-branch / mispredict counters
//   undefined -> both counter outputs tied to zero, no counter registers

module riscv_bpu #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_i,
  output logic            hit_o,
  output logic            taken_o,
  output logic [XLEN-1:0] predicted_pc_o,
  input  logic            flush_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_pc_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     No_branch_o,
  output logic [31:0]     No_mispredict_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Counter encodings: weakly-taken = MSB set, rest clear; weakly-not-taken = MSB clear, rest set.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign idx = pc_i[IDX_W+1:2];
  assign tag = pc_i[XLEN-1:IDX_W+2];

  assign hit_o          = valid_q[idx] && (tag_q[idx] == tag);
  assign taken_o        = hit_o && cnt_q[idx][CNT_W-1];
  assign predicted_pc_o = taken_o ? target_q[idx] : pc_i + XLEN'(4);

  // ---------------- redirect ----------------
  // The predicted next PC alone decides correctness: a taken prediction whose target
  // happens to equal pc+4 is not a mispredict, so the predicted direction is not needed.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken_i;

  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
  assign mispredict_o  = upd_valid_i && (redirect_pc_o != upd_pred_pc_i);

  // ---------------- training ----------------
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;

  assign uidx = upd_pc_i[IDX_W+1:2];
  assign utag = upd_pc_i[XLEN-1:IDX_W+2];
  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (flush_i) begin
      // Only valid bits drop; counters and targets keep their history.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid_i) begin
      if (uhit) begin
        if (upd_taken_i) begin
          if (cnt_q[uidx] != CNT_MAX) cnt_q[uidx] <= cnt_q[uidx] + 1'b1;
          target_q[uidx] <= upd_target_i;
        end else if (cnt_q[uidx] != '0) begin
          cnt_q[uidx] <= cnt_q[uidx] - 1'b1;
        end
      end else if (upd_taken_i) begin
        // Miss-and-taken replaces whatever occupies the slot.
        valid_q[uidx]  <= 1'b1;
        tag_q[uidx]    <= utag;
        target_q[uidx] <= upd_target_i;
        cnt_q[uidx]    <= CNT_WT;
      end
    end
  end

  // ---------------- performance counters ----------------
`ifdef RISCV_BPU_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else if (!flush_i) begin
      if (upd_valid_i && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict_o && (mp_cnt_q != 32'hFFFF_FFFF)) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign No_branch_o     = br_cnt_q;
  assign No_mispredict_o = mp_cnt_q;
`else
  assign No_branch_o     = 32'd0;
  assign No_mispredict_o = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_bpu.sv
// Directed bench for riscv_bpu (XLEN=32, ENTRIES=16, CNT_W=2).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well clear of the rising edge.

module tb_riscv_bpu;

  logic        clk;
  logic        rst_ni;
  logic [31:0] pc;
  logic        hit, taken;
  logic [31:0] pred_pc;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] n_branch, n_mispredict;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_bpu #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .pc_i            (pc),
    .hit_o           (hit),
    .taken_o         (taken),
    .predicted_pc_o  (pred_pc),
    .flush_i         (flush),
    .upd_valid_i     (upd_valid),
    .upd_pc_i        (upd_pc),
    .upd_taken_i     (upd_taken),
    .upd_target_i    (upd_target),
    .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_pc_i   (upd_pred_pc),
    .mispredict_o    (mispredict),
    .redirect_pc_o   (redirect_pc),
    .No_branch_o     (n_branch),
    .No_mispredict_o (n_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one training update on the falling edge; it commits on the next rising edge.
  // Successive calls keep upd_valid high, giving back-to-back updates.
  task automatic drive_upd(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                           input logic [31:0] ppc, input logic fl);
    @(negedge clk);
    upd_valid      = 1'b1;
    upd_pc         = p;
    upd_taken      = t;
    upd_target     = tgt;
    upd_pred_pc    = ppc;
    upd_pred_taken = (ppc != p + 32'd4);
    flush          = fl;
    #1;
  endtask

  // Idle the update port and present a lookup PC.
  task automatic look(input logic [31:0] p);
    @(negedge clk);
    upd_valid = 1'b0;
    flush     = 1'b0;
    pc        = p;
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; flush = 1'b0; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_pc = 32'h0; pc = 32'h100;
    #12;
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got=%b exp=0", hit); end
    n_tests++; if (taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got=%b exp=0", taken); end
    n_tests++; if (pred_pc !== 32'h104) begin n_fail++; $display("FAIL reset_pred got=%h exp=00000104", pred_pc); end
    n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
    n_tests++; if (n_branch !== 32'd0) begin n_fail++; $display("FAIL reset_nbranch got=%0d exp=0", n_branch); end
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_alloc;
    drive_upd(32'h100, 1'b1, 32'h200, 32'h104, 1'b0);
    pc = 32'h100; #1;
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict got=%b exp=1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL alloc_redirect got=%h exp=00000200", redirect_pc); end
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL alloc_no_bypass got=%b exp=0", hit); end
    look(32'h100);
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL alloc_hit got=%b exp=1", hit); end
    n_tests++; if (taken !== 1'b1) begin n_fail++; $display("FAIL alloc_taken got=%b exp=1", taken); end
    n_tests++; if (pred_pc !== 32'h200) begin n_fail++; $display("FAIL alloc_pred got=%h exp=00000200", pred_pc); end
  endtask

  task automatic test_counter;
    // 10 -> 11 -> 11 -> 11, correctly predicted each time
    drive_upd(32'h100, 1'b1, 32'h200, 32'h200, 1'b0);
    n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL cnt_correct_mispredict got=%b exp=0", mispredict); end
    drive_upd(32'h100, 1'b1, 32'h200, 32'h200, 1'b0);
    drive_upd(32'h100, 1'b1, 32'h200, 32'h200, 1'b0);
    // not taken: 11 -> 10, still predicted taken
    drive_upd(32'h100, 1'b0, 32'h200, 32'h200, 1'b0);
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL cnt_nt_mispredict got=%b exp=1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL cnt_nt_redirect got=%h exp=00000104", redirect_pc); end
    look(32'h100);
    n_tests++; if (taken !== 1'b1) begin n_fail++; $display("FAIL cnt_10_taken got=%b exp=1", taken); end
    n_tests++; if (pred_pc !== 32'h200) begin n_fail++; $display("FAIL cnt_10_pred got=%h exp=00000200", pred_pc); end
    // not taken again: 10 -> 01
    drive_upd(32'h100, 1'b0, 32'h200, 32'h200, 1'b0);
    look(32'h100);
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL cnt_01_hit got=%b exp=1", hit); end
    n_tests++; if (taken !== 1'b0) begin n_fail++; $display("FAIL cnt_01_taken got=%b exp=0", taken); end
    n_tests++; if (pred_pc !== 32'h104) begin n_fail++; $display("FAIL cnt_01_pred got=%h exp=00000104", pred_pc); end
  endtask

  task automatic test_conflict;
    drive_upd(32'h100, 1'b1, 32'h200, 32'h104, 1'b0);   // hit, 01 -> 10
    drive_upd(32'h140, 1'b1, 32'h280, 32'h144, 1'b0);   // same idx 0, evicts 0x100
    drive_upd(32'h180, 1'b0, 32'h300, 32'h184, 1'b0);   // miss, not taken: no change
    n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL miss_nt_mispredict got=%b exp=0", mispredict); end
    look(32'h100);
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL evict_old_hit got=%b exp=0", hit); end
    n_tests++; if (pred_pc !== 32'h104) begin n_fail++; $display("FAIL evict_old_pred got=%h exp=00000104", pred_pc); end
    look(32'h140);
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL evict_new_hit got=%b exp=1", hit); end
    n_tests++; if (pred_pc !== 32'h280) begin n_fail++; $display("FAIL evict_new_pred got=%h exp=00000280", pred_pc); end
    look(32'h180);
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_nt_alloc got=%b exp=0", hit); end
    // saturate at zero: 10 -> 01 -> 00 -> 00, then taken -> 01 (still not taken)
    drive_upd(32'h140, 1'b0, 32'h0, 32'h280, 1'b0);
    drive_upd(32'h140, 1'b0, 32'h0, 32'h144, 1'b0);
    drive_upd(32'h140, 1'b0, 32'h0, 32'h144, 1'b0);
    drive_upd(32'h140, 1'b1, 32'h280, 32'h144, 1'b0);
    look(32'h140);
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL sat0_hit got=%b exp=1", hit); end
    n_tests++; if (taken !== 1'b0) begin n_fail++; $display("FAIL sat0_taken got=%b exp=0", taken); end
    n_tests++; if (pred_pc !== 32'h144) begin n_fail++; $display("FAIL sat0_pred got=%h exp=00000144", pred_pc); end
  endtask

  task automatic test_flush;
    drive_upd(32'h300, 1'b1, 32'h400, 32'h304, 1'b1);
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL flush_mispredict got=%b exp=1", mispredict); end
    look(32'h140);
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_old_hit got=%b exp=0", hit); end
    look(32'h300);
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_hit got=%b exp=0", hit); end
    n_tests++; if (pred_pc !== 32'h304) begin n_fail++; $display("FAIL flush_dropped_pred got=%h exp=00000304", pred_pc); end
    drive_upd(32'h140, 1'b1, 32'h280, 32'h144, 1'b0);
    look(32'h140);
    n_tests++; if (taken !== 1'b1) begin n_fail++; $display("FAIL post_flush_taken got=%b exp=1", taken); end
  endtask

  task automatic test_wrap;
    look(32'hFFFF_FFFC);
    n_tests++; if (pred_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pred got=%h exp=00000000", pred_pc); end
    drive_upd(32'hFFFF_FFFC, 1'b0, 32'h1234, 32'h0, 1'b0);
    n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_redirect got=%h exp=00000000", redirect_pc); end
    n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL wrap_mispredict got=%b exp=0", mispredict); end
  endtask

  // 15 unflushed updates so far, 8 of them mispredicted.
  task automatic test_perf;
    look(32'h0);
`ifdef RISCV_BPU_PERF_CNT_EN
    n_tests++; if (n_branch !== 32'd15) begin n_fail++; $display("FAIL perf_branch got=%0d exp=15", n_branch); end
    n_tests++; if (n_mispredict !== 32'd8) begin n_fail++; $display("FAIL perf_mispredict got=%0d exp=8", n_mispredict); end
`else
    n_tests++; if (n_branch !== 32'd0) begin n_fail++; $display("FAIL perf_branch got=%0d exp=0", n_branch); end
    n_tests++; if (n_mispredict !== 32'd0) begin n_fail++; $display("FAIL perf_mispredict got=%0d exp=0", n_mispredict); end
`endif
  endtask

  task automatic test_async_reset;
    look(32'h140);
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL pre_arst_hit got=%b exp=1", hit); end
    #1 rst_ni = 1'b0;
    #1;
    n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL arst_hit got=%b exp=0", hit); end
    n_tests++; if (n_mispredict !== 32'd0) begin n_fail++; $display("FAIL arst_perf got=%0d exp=0", n_mispredict); end
    @(negedge clk);
    rst_ni = 1'b1;
    drive_upd(32'h140, 1'b1, 32'h2C0, 32'h144, 1'b0);
    look(32'h140);
    n_tests++; if (pred_pc !== 32'h2C0) begin n_fail++; $display("FAIL arst_first_upd got=%h exp=000002c0", pred_pc); end
`ifdef RISCV_BPU_PERF_CNT_EN
    n_tests++; if (n_branch !== 32'd1) begin n_fail++; $display("FAIL arst_perf_count got=%0d exp=1", n_branch); end
`endif
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_conflict();
    test_flush();
    test_wrap();
    test_perf();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

endmodule
